hazard_forward_unit: RTL and testbench

//  Parametrised hazard unit for the 5-stage pipeline: tracks in-flight writes (dest reg, Tnew) for
//  E/M/W, generates D-stage stall by Tuse/Tnew compare, and drives forward-mux selects for D, E and M.

---
 rtl/hazard_forward_unit.sv | 80 ++++++++
 tb/tb_hazard_forward_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: Tuse/Tnew stall generation, D/E/M forward selects and MDU busy tracking
module hazard_forward_unit #(
    parameter int REG_AW      = 5,
    parameter int TW          = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] D_rs_addr,
    input  logic [REG_AW-1:0] D_rt_addr,
    input  logic [TW-1:0]     D_tuse_rs,
    input  logic [TW-1:0]     D_tuse_rt,
    input  logic [REG_AW-1:0] D_wa,
    input  logic [TW-1:0]     D_tnew,
    input  logic              D_md_start,
    input  logic              D_md_div,
    input  logic              D_md_use,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        D_fwd_rs,
    output logic [1:0]        D_fwd_rt,
    output logic [1:0]        E_fwd_rs,
    output logic [1:0]        E_fwd_rt,
    output logic [1:0]        M_fwd_rt,
    output logic              md_busy
);
    localparam int CMAX = DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    logic [REG_AW-1:0] e_rs, e_rt, e_wa, m_rt, m_wa, w_wa;
    logic [TW-1:0]     e_tnew, m_tnew;
    logic              e_md_start, e_md_div;
    logic [CW-1:0]     cnt;
    logic              rs_hz, rt_hz;

    // Closest producer wins; a producer not yet ready yields 0 because stall covers it
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] a, e, m, w,
                                           input logic e_rdy, m_rdy);
        return a == '0 ? 2'd0 :
               a == e  ? (e_rdy ? 2'd1 : 2'd0) :
               a == m  ? (m_rdy ? 2'd2 : 2'd0) :
               a == w  ? 2'd3 : 2'd0;
    endfunction

    assign rs_hz = D_tuse_rs != '1 && D_rs_addr != '0 &&
                   ((e_wa == D_rs_addr && e_tnew > D_tuse_rs) || (m_wa == D_rs_addr && m_tnew > D_tuse_rs));
    assign rt_hz = D_tuse_rt != '1 && D_rt_addr != '0 &&
                   ((e_wa == D_rt_addr && e_tnew > D_tuse_rt) || (m_wa == D_rt_addr && m_tnew > D_tuse_rt));
    assign stall    = rs_hz || rt_hz || (D_md_use && (cnt != '0 || e_md_start));
    assign md_busy  = cnt != '0;
    assign D_fwd_rs = fwd_sel(D_rs_addr, e_wa, m_wa, w_wa, e_tnew == '0, m_tnew == '0);
    assign D_fwd_rt = fwd_sel(D_rt_addr, e_wa, m_wa, w_wa, e_tnew == '0, m_tnew == '0);
    assign E_fwd_rs = fwd_sel(e_rs, '0, m_wa, w_wa, 1'b0, m_tnew == '0);
    assign E_fwd_rt = fwd_sel(e_rt, '0, m_wa, w_wa, 1'b0, m_tnew == '0);
    assign M_fwd_rt = fwd_sel(m_rt, '0, '0, w_wa, 1'b0, 1'b0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {e_rs, e_rt, e_wa, e_tnew, e_md_start, e_md_div} <= '0;
            {m_rt, m_wa, m_tnew} <= '0;
            w_wa <= '0;
            cnt  <= '0;
        end else begin
            if (flush || stall)
                {e_rs, e_rt, e_wa, e_tnew, e_md_start, e_md_div} <= '0;
            else
                {e_rs, e_rt, e_wa, e_tnew, e_md_start, e_md_div} <=
                    {D_rs_addr, D_rt_addr, D_wa, D_tnew, D_md_start, D_md_div};
            if (flush)
                {m_rt, m_wa, m_tnew} <= '0;
            else
                {m_rt, m_wa, m_tnew} <= {e_rt, e_wa, e_tnew == '0 ? e_tnew : e_tnew - 1'b1};
            w_wa <= m_wa;
            // A flush squashes the issuing op but never an MDU operation already running
            cnt  <= (e_md_start && !flush) ? (e_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) :
                    cnt != '0 ? cnt - 1'b1 : cnt;
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed pipeline scenarios checked through an expected-output scoreboard
module tb_hazard_forward_unit;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] D_rs_addr, D_rt_addr, D_wa;
    logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
    logic       D_md_start, D_md_div, D_md_use, flush;
    logic       stall, md_busy;
    logic [1:0] D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt;

    int total = 0;
    int bad = 0;
    logic [11:0] sb[$];
    string       tq[$];

    hazard_forward_unit dut (
        .clk(clk), .reset_n(reset_n),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_wa(D_wa), .D_tnew(D_tnew),
        .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
        .flush(flush), .stall(stall),
        .D_fwd_rs(D_fwd_rs), .D_fwd_rt(D_fwd_rt),
        .E_fwd_rs(E_fwd_rs), .E_fwd_rt(E_fwd_rt), .M_fwd_rt(M_fwd_rt),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ex(input logic st, input logic [1:0] dr, dt, er, et, mt,
                                       input logic busy);
        return {st, dr, dt, er, et, mt, busy};
    endfunction

    task automatic set_d(input logic [4:0] rs, rt, input logic [1:0] urs, urt,
                         input logic [4:0] wa, input logic [1:0] tn,
                         input logic ms, md, mu, fl);
        D_rs_addr = rs; D_rt_addr = rt; D_tuse_rs = urs; D_tuse_rt = urt;
        D_wa = wa; D_tnew = tn; D_md_start = ms; D_md_div = md; D_md_use = mu; flush = fl;
    endtask

    task automatic nop(input logic fl);
        set_d(0, 0, 3, 3, 0, 0, 0, 0, 0, fl);
    endtask

    task automatic chk(input string tag, input logic [11:0] e);
        logic [11:0] got, want;
        string t;
        sb.push_back(e);
        tq.push_back(tag);
        @(negedge clk);
        got  = {stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt, md_busy};
        want = sb.pop_front();
        t    = tq.pop_front();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", t, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            set_d(5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom), 5'($urandom),
                  2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("reset", ex(0, 0, 0, 0, 0, 0, 0));
        end
        reset_n = 1'b1;
        // load-use
        set_d(29, 0, 1, 3, 8, 2, 0, 0, 0, 0);  chk("lw_first", ex(0, 0, 0, 0, 0, 0, 0));
        set_d(8, 9, 1, 1, 10, 1, 0, 0, 0, 0);  chk("load_use_stall", ex(1, 0, 0, 0, 0, 0, 0));
        chk("load_use_release", ex(0, 0, 0, 0, 0, 0, 0));
        nop(0);                                chk("load_use_e_fwd_w", ex(0, 0, 0, 3, 0, 0, 0));
        // ALU chain
        set_d(1, 2, 1, 1, 9, 1, 0, 0, 0, 0);   chk("alu_prod", ex(0, 0, 0, 0, 0, 0, 0));
        set_d(9, 0, 0, 3, 11, 1, 0, 0, 0, 0);  chk("alu_tuse0_stall", ex(1, 0, 0, 0, 0, 0, 0));
        chk("alu_tuse0_d_fwd_m", ex(0, 2, 0, 0, 0, 0, 0));
        set_d(11, 9, 1, 1, 12, 1, 0, 0, 0, 0); chk("alu_tuse1_nostall", ex(0, 0, 3, 3, 0, 0, 0));
        nop(0);                                chk("alu_tuse1_e_fwd_m", ex(0, 0, 0, 2, 0, 0, 0));
        // jal / jr
        set_d(0, 0, 3, 3, 31, 0, 0, 0, 0, 0);  chk("jal", ex(0, 0, 0, 0, 0, 0, 0));
        set_d(31, 0, 0, 3, 0, 0, 0, 0, 0, 0);  chk("jr_d_fwd_e", ex(0, 1, 0, 0, 0, 0, 0));
        // $0 destination never hazards
        set_d(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);   chk("zero_dest", ex(0, 0, 0, 2, 0, 0, 0));
        set_d(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);   chk("zero_use", ex(0, 0, 0, 0, 0, 0, 0));
        // store data through E then M
        set_d(0, 5, 3, 2, 0, 0, 0, 0, 0, 0);   chk("sw_tuse2", ex(0, 0, 0, 0, 0, 0, 0));
        nop(0);                                chk("sw_e_fwd_rt_m", ex(0, 0, 0, 0, 2, 0, 0));
        nop(0);                                chk("sw_m_fwd_w", ex(0, 0, 0, 0, 0, 3, 0));
        // closest stage wins
        set_d(0, 0, 3, 3, 7, 1, 0, 0, 0, 0);   chk("prio_a", ex(0, 0, 0, 0, 0, 0, 0));
        set_d(0, 0, 3, 3, 7, 0, 0, 0, 0, 0);   chk("prio_b", ex(0, 0, 0, 0, 0, 0, 0));
        set_d(7, 0, 0, 3, 0, 0, 0, 0, 0, 0);   chk("prio_d_e_over_m", ex(0, 1, 0, 0, 0, 0, 0));
        nop(0);                                chk("prio_e_m_over_w", ex(0, 0, 0, 2, 0, 0, 0));
        // flush kills the E load and the M record
        set_d(0, 0, 3, 3, 9, 1, 0, 0, 0, 1);   chk("flush_e", ex(0, 0, 0, 0, 0, 0, 0));
        set_d(9, 0, 0, 3, 0, 0, 0, 0, 0, 0);   chk("flush_e_gone", ex(0, 0, 0, 0, 0, 0, 0));
        set_d(0, 0, 3, 3, 9, 2, 0, 0, 0, 0);   chk("flush_m_prod", ex(0, 0, 0, 0, 0, 0, 0));
        nop(1);                                chk("flush_m", ex(0, 0, 0, 0, 0, 0, 0));
        set_d(9, 0, 0, 3, 0, 0, 0, 0, 0, 0);   chk("flush_m_gone", ex(0, 0, 0, 0, 0, 0, 0));
        // div then mflo, flush mid-count
        set_d(0, 0, 3, 3, 0, 0, 1, 1, 1, 0);   chk("div_issue", ex(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++) begin
            set_d(0, 0, 3, 3, 0, 0, 0, 0, 1, i == 5);
            chk($sformatf("mflo_wait_%0d", i), ex(i < 11, 0, 0, 0, 0, 0, i >= 1 && i <= 10));
        end
        // mult busy window without MDU access
        set_d(0, 0, 3, 3, 0, 0, 1, 0, 1, 0);   chk("mult_issue", ex(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++) begin
            nop(0);
            chk($sformatf("mult_busy_%0d", i), ex(0, 0, 0, 0, 0, 0, i >= 1 && i <= 5));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
